// File: rtl/mem_subsystem.sv
// 32 x 8 single-port storage array for the memory tester bus.
// Single-cycle read/write commands; read data is returned on a registered output.
module mem_subsystem #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  rd_en;
  logic                  wr_en;

  // Read and write together, or any unknown on either command, decode as no-op.
  always_comb begin
    rd_en = 1'b0;
    wr_en = 1'b0;
    if ((read == 1'b1) && (write == 1'b0)) rd_en = 1'b1;
    if ((write == 1'b1) && (read == 1'b0)) wr_en = 1'b1;
  end

  always_comb begin
    data_d = data_q;
    if (rd_en) data_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      data_q <= '0;
    end else begin
      if (wr_en) mem_q[addr] <= data_in;
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_mem_subsystem.sv
// Self-checking bench for mem_subsystem: directed test-plan steps followed by
// randomized traffic, all checked against a word-array reference model.
`timescale 1ns/1ns
module tb_mem_subsystem;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] ref_mem [32];
  logic [7:0] ref_out;

  mem_subsystem #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one command away from the edge, let the edge happen, then advance the
  // model by the documented rules and compare the registered output.
  task automatic cycle(input logic r, input logic rd, input logic wr,
                       input logic [4:0] a, input logic [7:0] d, input string tag);
    @(negedge clk);
    rst = r; read = rd; write = wr; addr = a; data_in = d;
    @(posedge clk);
    #1;
    if (r) begin
      foreach (ref_mem[i]) ref_mem[i] = 8'h00;
      ref_out = 8'h00;
    end else if (rd && !wr) begin
      ref_out = ref_mem[a];
    end else if (wr && !rd) begin
      ref_mem[a] = d;
    end
    check(tag, data_out, ref_out);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    cycle(1'b0, 1'b0, 1'b1, a, d, "write_hold");
  endtask

  task automatic do_read(input logic [4:0] a);
    cycle(1'b0, 1'b1, 1'b0, a, 8'h00, "read");
  endtask

  initial begin
    logic [7:0] held;
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    ref_out = 8'h00;

    // Reset for two cycles; output and every location must read zero.
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 8'h00, "reset1");
    cycle(1'b1, 1'b1, 1'b1, 5'd7, 8'hEE, "reset2");
    check("reset_out", data_out, 8'h00);
    for (int i = 0; i < 32; i++) begin
      do_read(i[4:0]);
      check("reset_read", data_out, 8'h00);
    end

    // Address-as-data.
    for (int i = 0; i < 32; i++) do_write(i[4:0], i[7:0]);
    for (int i = 0; i < 32; i++) begin
      do_read(i[4:0]);
      check("addr_as_data", data_out, i[7:0]);
    end
    do_read(5'd17);
    check("addr17", data_out, 8'h11);

    // Random bytes to every location, then read back.
    for (int i = 0; i < 32; i++) do_write(i[4:0], 8'($urandom));
    for (int i = 0; i < 32; i++) do_read(i[4:0]);

    // Extreme values at the boundary addresses.
    do_write(5'd31, 8'hFF);
    do_write(5'd0, 8'h00);
    do_read(5'd31);
    check("addr31_ff", data_out, 8'hFF);
    do_read(5'd0);
    check("addr0_00", data_out, 8'h00);

    // Illegal read+write must neither write nor update the output.
    do_write(5'd3, 8'hA5);
    do_read(5'd0);
    held = data_out;
    cycle(1'b0, 1'b1, 1'b1, 5'd3, 8'h5A, "illegal");
    check("illegal_hold", data_out, held);
    do_read(5'd3);
    check("illegal_nowrite", data_out, 8'hA5);

    // Idle cycles hold the output.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 5'($urandom), 8'($urandom), "idle");
      check("idle_hold", data_out, 8'hA5);
    end

    // Back-to-back write then read of the same address.
    do_write(5'd9, 8'h3C);
    do_read(5'd9);
    check("wr_then_rd", data_out, 8'h3C);

    // Reset alongside a write discards the write and clears the array.
    do_write(5'd12, 8'h77);
    cycle(1'b1, 1'b0, 1'b1, 5'd12, 8'h11, "mid_reset");
    do_read(5'd12);
    check("mid_reset_rd", data_out, 8'h00);

    // Randomized mixed traffic, including occasional reset and illegal commands.
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 2)
        cycle(1'b1, 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom), "rand_reset");
      else if (sel < 40)
        cycle(1'b0, 1'b0, 1'b1, 5'($urandom), 8'($urandom), "rand_write");
      else if (sel < 85)
        cycle(1'b0, 1'b1, 1'b0, 5'($urandom), 8'($urandom), "rand_read");
      else if (sel < 92)
        cycle(1'b0, 1'b1, 1'b1, 5'($urandom), 8'($urandom), "rand_illegal");
      else
        cycle(1'b0, 1'b0, 1'b0, 5'($urandom), 8'($urandom), "rand_idle");
    end

    // Final sweep so every location is compared after the random traffic.
    for (int i = 0; i < 32; i++) do_read(i[4:0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
